// File: rtl/h264intra4x4_recon.sv
// Intra 4x4 reconstruction: base-row FIFO, residual add, clip, feedback.
// Optional clip statistics counter enabled by H264_RECON_CLIPSTAT_EN.
module h264intra4x4_recon #(
  parameter int BASE_DEPTH = 4,
  parameter int RES_W      = 10
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              NEWSLICE,
  input  logic              BSTROBEI,
  input  logic [31:0]       BASEI,
  input  logic              XSTROBEI,
  input  logic [4*RES_W-1:0] XI,
  output logic              READY,
  output logic              FBSTROBE,
  output logic [31:0]       FBO,
  output logic [3:0]        SUBMBO,
  output logic [1:0]        ROWO,
  output logic              MBDONE,
  output logic              ERR
`ifdef H264_RECON_CLIPSTAT_EN
  ,
  output logic [15:0]       CLIPCNT
`endif
);

  localparam int AW = $clog2(BASE_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, MBEND} state_t;

  state_t          state, state_nx;
  logic [31:0]     mem [BASE_DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            ready_prev, ready_d;
  logic [1:0]      row_cnt;
  logic [3:0]      sub_cnt;
  logic            push_req, pop_req, push, pop;
  logic            drop, miss, flush_err, last;
  logic [31:0]     base, clip_w;
  logic signed [RES_W:0] s;
`ifdef H264_RECON_CLIPSTAT_EN
  logic [2:0]      nclip;
  logic [16:0]     clip_sum;
`endif

  // A push is honoured while READY is high and for the one cycle after it drops
  assign push_req  = BSTROBEI && (READY || ready_prev) && (state == LOAD);
  assign pop_req   = XSTROBEI && (state == LOAD);
  assign pop       = pop_req && (cnt != '0);
  assign push      = push_req && ((cnt < CW'(BASE_DEPTH)) || pop);
  assign drop      = push_req && !push;
  assign miss      = pop_req && (cnt == '0);
  assign flush_err = (state == MBEND) && (cnt != '0);
  assign last      = pop && (row_cnt == 2'd3) && (sub_cnt == 4'd15);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: state_nx = LOAD;
      LOAD: begin
        cnt_nx = cnt + CW'(push) - CW'(pop);
        if (last) state_nx = MBEND;
      end
      MBEND: begin
        state_nx = LOAD;
        cnt_nx   = '0;
      end
      default: state_nx = IDLE;
    endcase
    ready_d = (state_nx == LOAD)
           && (cnt_nx < CW'(BASE_DEPTH))
           && !((cnt_nx == CW'(BASE_DEPTH - 1)) && BSTROBEI);
  end

  always_comb begin
    base   = mem[rd_ptr];
    clip_w = '0;
    s      = '0;
`ifdef H264_RECON_CLIPSTAT_EN
    nclip  = '0;
`endif
    for (int i = 0; i < 4; i++) begin
      s = $signed({{(RES_W-7){1'b0}}, base[8*i +: 8]})
        + $signed({XI[RES_W*i+RES_W-1], XI[RES_W*i +: RES_W]});
      if (s[RES_W]) begin
`ifdef H264_RECON_CLIPSTAT_EN
        nclip = nclip + 3'd1;
`endif
      end else if (|s[RES_W-1:8]) begin
        clip_w[8*i +: 8] = 8'hFF;
`ifdef H264_RECON_CLIPSTAT_EN
        nclip = nclip + 3'd1;
`endif
      end else begin
        clip_w[8*i +: 8] = s[7:0];
      end
    end
  end

`ifdef H264_RECON_CLIPSTAT_EN
  assign clip_sum = {1'b0, CLIPCNT} + 17'(nclip);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)         CLIPCNT <= '0;
    else if (NEWSLICE) CLIPCNT <= '0;
    else if (pop)
      CLIPCNT <= clip_sum[16] ? 16'hFFFF : clip_sum[15:0];
  end
`endif

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= BASEI;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      cnt        <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      READY      <= 1'b0;
      ready_prev <= 1'b0;
      FBSTROBE   <= 1'b0;
      FBO        <= '0;
      SUBMBO     <= '0;
      ROWO       <= '0;
      MBDONE     <= 1'b0;
      ERR        <= 1'b0;
      row_cnt    <= '0;
      sub_cnt    <= '0;
    end else if (NEWSLICE) begin
      state      <= IDLE;
      cnt        <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      READY      <= 1'b0;
      ready_prev <= 1'b0;
      FBSTROBE   <= 1'b0;
      FBO        <= '0;
      SUBMBO     <= '0;
      ROWO       <= '0;
      MBDONE     <= 1'b0;
      ERR        <= 1'b0;
      row_cnt    <= '0;
      sub_cnt    <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      READY      <= ready_d;
      ready_prev <= READY;
      FBSTROBE   <= pop;
      MBDONE     <= (state == MBEND);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        FBO     <= clip_w;
        SUBMBO  <= sub_cnt;
        ROWO    <= row_cnt;
        row_cnt <= row_cnt + 2'd1;
        if (row_cnt == 2'd3) sub_cnt <= sub_cnt + 4'd1;
      end
      // Leftover rows at macroblock end are stale; drop them
      if (state == MBEND) rd_ptr <= wr_ptr;
      if (drop || miss || flush_err) ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_h264intra4x4_recon.sv
// Self-checking bench for h264intra4x4_recon.
// Queue-based reference model plus directed literal expectations.
module tb_h264intra4x4_recon;

  localparam int DEPTH = 4;
  localparam int RW    = 10;
  localparam int XW    = 4 * RW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ns  = 1'b0;
  logic          bs  = 1'b0;
  logic [31:0]   bv  = '0;
  logic          xs  = 1'b0;
  logic [XW-1:0] xv  = '0;
  logic          READY, FBSTROBE, MBDONE, ERR;
  logic [31:0]   FBO;
  logic [3:0]    SUBMBO;
  logic [1:0]    ROWO;
`ifdef H264_RECON_CLIPSTAT_EN
  logic [15:0]   CLIPCNT;
`endif

  int checks = 0;
  int errors = 0;

  h264intra4x4_recon #(.BASE_DEPTH(DEPTH), .RES_W(RW)) dut (
    .CLK(clk), .RESET(rst), .NEWSLICE(ns),
    .BSTROBEI(bs), .BASEI(bv), .XSTROBEI(xs), .XI(xv),
    .READY(READY), .FBSTROBE(FBSTROBE), .FBO(FBO),
    .SUBMBO(SUBMBO), .ROWO(ROWO), .MBDONE(MBDONE), .ERR(ERR)
`ifdef H264_RECON_CLIPSTAT_EN
    , .CLIPCNT(CLIPCNT)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] q[$];
  int  ph;
  bit  e_ready, e_prev, e_fb, e_mbdone, e_err;
  logic [31:0] e_fbo;
  int  e_sub, e_row, rowc, subc, e_clip;

  function automatic int clip(input int v, inout int nc);
    if (v < 0) begin nc++; return 0; end
    if (v > 255) begin nc++; return 255; end
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    ph = 0; e_ready = 0; e_prev = 0; e_fb = 0; e_mbdone = 0;
    e_err = 0; e_fbo = '0; e_sub = 0; e_row = 0;
    rowc = 0; subc = 0; e_clip = 0;
  endtask

  task automatic model_step();
    bit old_ready;
    bit win;
    logic [31:0] b;
    logic signed [RW-1:0] r;
    int nc, sz;
    old_ready = e_ready;
    e_fb = 0;
    e_mbdone = (ph == 2);
    if (ns) begin
      model_reset();
      return;
    end
    case (ph)
      0: ph = 1;
      1: begin
        win = e_ready || e_prev;
        if (xs) begin
          if (q.size() > 0) begin
            b = q.pop_front();
            nc = 0;
            for (int i = 0; i < 4; i++) begin
              r = xv[i*RW +: RW];
              e_fbo[8*i +: 8] = 8'(clip(int'(b[8*i +: 8]) + int'(r), nc));
            end
            e_fb = 1;
            e_sub = subc;
            e_row = rowc;
            e_clip = (e_clip + nc > 65535) ? 65535 : e_clip + nc;
            rowc = (rowc + 1) % 4;
            if (rowc == 0) subc = (subc + 1) % 16;
            if (rowc == 0 && subc == 0) ph = 2;
          end else e_err = 1;
        end
        if (bs && win) begin
          if (q.size() < DEPTH) q.push_back(bv);
          else e_err = 1;
        end
      end
      default: begin
        if (q.size() != 0) e_err = 1;
        q.delete();
        ph = 1;
      end
    endcase
    e_prev = old_ready;
    sz = q.size();
    e_ready = (ph == 1) && (sz < DEPTH) && !(sz == DEPTH - 1 && bs);
  endtask

  // observations used by directed checks
  int fb_cnt = 0, mb_cnt = 0;
  logic [31:0] last_fbo = '0;
  logic [3:0]  last_sub = '0;
  logic [1:0]  last_row = '0;

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
      #1;
      chk("ready", 32'(READY), 32'(e_ready));
      chk("fbstrobe", 32'(FBSTROBE), 32'(e_fb));
      chk("fbo", FBO, e_fbo);
      chk("submbo", 32'(SUBMBO), 32'(e_sub));
      chk("rowo", 32'(ROWO), 32'(e_row));
      chk("mbdone", 32'(MBDONE), 32'(e_mbdone));
      chk("err", 32'(ERR), 32'(e_err));
`ifdef H264_RECON_CLIPSTAT_EN
      chk("clipcnt", 32'(CLIPCNT), 32'(e_clip));
`endif
      if (FBSTROBE) begin
        fb_cnt++;
        last_fbo = FBO;
        last_sub = SUBMBO;
        last_row = ROWO;
      end
      if (MBDONE) mb_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [XW-1:0] pack(input int a, input int b,
                                         input int c, input int d);
    return {RW'(d), RW'(c), RW'(b), RW'(a)};
  endfunction

  task automatic step(input bit b, input logic [31:0] bval, input bit x,
                      input logic [XW-1:0] xval, input bit n);
    @(negedge clk);
    bs = b; bv = bval; xs = x; xv = xval; ns = n;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, '0, 0);
  endtask

  task automatic pair(input logic [31:0] b, input logic [XW-1:0] x);
    step(1, b, 0, '0, 0);
    step(0, '0, 1, x, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int fb0, mb0;
`ifdef H264_RECON_CLIPSTAT_EN
    int c0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(READY), 32'd0);
    chk("rst_fbo", FBO, 32'd0);
    rst = 1'b0;
    #1;
    chk("first_cycle_ready", 32'(READY), 32'd0);
    @(posedge clk); #1;
    chk("second_cycle_ready", 32'(READY), 32'd1);

    // basic +1 reconstruction
    for (int i = 0; i < 4; i++) step(1, 32'h80808080, 0, '0, 0);
    for (int i = 0; i < 4; i++) step(0, '0, 1, pack(1, 1, 1, 1), 0);
    idle(1);
    chk("basic_count", 32'(fb_cnt), 32'd4);
    chk("basic_fbo", last_fbo, 32'h81818181);
    chk("basic_row", 32'(last_row), 32'd3);
    chk("basic_sub", 32'(last_sub), 32'd0);

    // clipping
`ifdef H264_RECON_CLIPSTAT_EN
    c0 = int'(CLIPCNT);
`endif
    pair(32'hFF00FF00, pack(5, -5, -300, 300));
    idle(1);
    chk("clip_mixed", last_fbo, 32'hFF00FA05);
`ifdef H264_RECON_CLIPSTAT_EN
    chk("clipcnt_2", 32'(int'(CLIPCNT) - c0), 32'd2);
    c0 = int'(CLIPCNT);
`endif
    pair(32'hFF00FF00, pack(-300, 300, -300, 300));
    idle(1);
    chk("clip_all", last_fbo, 32'hFF00FF00);
`ifdef H264_RECON_CLIPSTAT_EN
    chk("clipcnt_4", 32'(int'(CLIPCNT) - c0), 32'd4);
`endif

    // full macroblock
    step(0, '0, 0, '0, 1);
    idle(2);
    fb0 = fb_cnt;
    mb0 = mb_cnt;
    for (int k = 0; k < 64; k++)
      pair({8'(k*3), 8'(k*5+1), 8'(255-k), 8'(k)},
           pack(k % 7 - 3, 20 - k, k*9 - 250, (k*13) % 600 - 300));
    idle(3);
    chk("mb_rows", 32'(fb_cnt - fb0), 32'd64);
    chk("mb_done_once", 32'(mb_cnt - mb0), 32'd1);
    chk("mb_err", 32'(ERR), 32'd0);
    chk("mb_last_sub", 32'(last_sub), 32'd15);

    // back-pressure
    fb0 = fb_cnt;
    for (int k = 1; k <= 3; k++) step(1, 32'(k) * 32'h11111111, 0, '0, 0);
    step(1, 32'h44444444, 0, '0, 0);
    chk("bp_ready_low", 32'(READY), 32'd0);
    step(1, 32'h55555555, 0, '0, 0);
    step(1, 32'h66666666, 0, '0, 0);
    idle(1);
    chk("bp_no_err", 32'(ERR), 32'd0);
    for (int k = 0; k < 5; k++) step(0, '0, 1, pack(0, 0, 0, 0), 0);
    idle(2);
    chk("bp_rows", 32'(fb_cnt - fb0), 32'd4);
    chk("bp_last", last_fbo, 32'h44444444);
    chk("empty_err", 32'(ERR), 32'd1);
    idle(3);
    chk("err_sticky", 32'(ERR), 32'd1);
    step(0, '0, 0, '0, 1);
    idle(1);
    chk("ns_err", 32'(ERR), 32'd0);
    chk("ns_sub", 32'(SUBMBO), 32'd0);
    chk("ns_row", 32'(ROWO), 32'd0);

    // simultaneous push/pop on empty FIFO
    idle(1);
    step(1, 32'h12345678, 1, pack(0, 0, 0, 0), 0);
    idle(1);
    chk("simul_err", 32'(ERR), 32'd1);
    step(0, '0, 1, pack(1, 1, 1, 1), 0);
    idle(1);
    chk("simul_row_kept", last_fbo, 32'h13355779);

    // async reset mid-macroblock
    step(0, '0, 0, '0, 1);
    idle(2);
    for (int k = 0; k < 31; k++) pair(32'h40404040, pack(k, 0, -k, 2));
    idle(1);
    chk("mid_sub", 32'(last_sub), 32'd7);
    chk("mid_row", 32'(last_row), 32'd2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("ar_ready", 32'(READY), 32'd0);
    chk("ar_fbo", FBO, 32'd0);
    chk("ar_sub", 32'(SUBMBO), 32'd0);
    chk("ar_row", 32'(ROWO), 32'd0);
    chk("ar_err", 32'(ERR), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    pair(32'h01010101, pack(1, 2, 3, 4));
    idle(1);
    chk("restart_sub", 32'(last_sub), 32'd0);
    chk("restart_row", 32'(last_row), 32'd0);
    chk("restart_fbo", last_fbo, 32'h05040302);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
